// File: rtl/ch376s_spi_responder.sv
// rtl/ch376s_spi_responder.sv - SPI mode-0 responder modelling the CH376S end of the USB host link
// MOSI bytes are deserialised, MISO bytes come from a small TX FIFO; with CS high MISO carries ~int_req.
module ch376s_spi_responder #(
  parameter int         TX_DEPTH    = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_sck,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic                        rx_cmd,
  output logic                        frame_end,
  output logic                        cs_active,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_full,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  input  logic                        int_req
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Synchronisers; cs_n resets low so a frame already in progress after reset is never joined.
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // TX FIFO
  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, fifo_full;
  logic          pop_req, pop, push;
  logic [7:0]    load_byte;

  state_t        state_q;
  logic [3:0]    bit_cnt_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(TX_DEPTH));
  assign load_byte  = fifo_empty ? IDLE_BYTE : mem_q[rd_ptr_q];

  // A load happens at frame start and at each byte boundary; a cs_n rise in the same clk wins.
  assign pop_req = ((state_q == IDLE) && cs_fall) ||
                   ((state_q == ACTIVE) && !cs_rise && sck_fall && (bit_cnt_q == 4'd0));
  assign pop     = pop_req & ~fifo_empty;
  assign push    = tx_wr & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign tx_full  = fifo_full;
  assign tx_count = count_q;

  // Frame state machine with registered outputs
  logic       first_byte_q;
  logic [7:0] rx_shift_q, tx_shift_q, rx_data_q;
  logic       miso_q, rx_valid_q, rx_cmd_q, frame_end_q, cs_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= 4'd0;
      first_byte_q <= 1'b0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      miso_q       <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_cmd_q     <= 1'b0;
      frame_end_q  <= 1'b0;
      cs_active_q  <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_end_q <= 1'b0;
      cs_active_q <= (state_q != WAIT_IDLE) && !cs_s;
      case (state_q)
        WAIT_IDLE: begin
          miso_q <= ~int_req;
          if (cs_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            state_q      <= ACTIVE;
            bit_cnt_q    <= 4'd0;
            first_byte_q <= 1'b1;
            tx_shift_q   <= load_byte;
            miso_q       <= load_byte[7];
          end else begin
            miso_q <= ~int_req;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            frame_end_q <= 1'b1;
            bit_cnt_q   <= 4'd0;
            miso_q      <= ~int_req;
          end else begin
            if (bit_cnt_q == 4'd8) begin
              rx_data_q    <= rx_shift_q;
              rx_valid_q   <= 1'b1;
              rx_cmd_q     <= first_byte_q;
              first_byte_q <= 1'b0;
              bit_cnt_q    <= 4'd0;
            end else if (sck_rise) begin
              rx_shift_q <= {rx_shift_q[6:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 4'd1;
            end
            if (sck_fall) begin
              if (bit_cnt_q == 4'd0) begin
                tx_shift_q <= load_byte;
                miso_q     <= load_byte[7];
              end else if (bit_cnt_q != 4'd8) begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                miso_q     <= tx_shift_q[6];
              end
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign spi_miso  = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_cmd    = rx_cmd_q;
  assign frame_end = frame_end_q;
  assign cs_active = cs_active_q;

endmodule

// File: tb/tb_ch376s_spi_responder.sv
// tb/tb_ch376s_spi_responder.sv - directed bench for ch376s_spi_responder with a byte-level model
module tb_ch376s_spi_responder;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int HP    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid, rx_cmd, frame_end, cs_active;
  logic [7:0] tx_data;
  logic       tx_wr, tx_full;
  logic [2:0] tx_count;
  logic       int_req;

  always #5 clk = ~clk;

  ch376s_spi_responder #(.TX_DEPTH(DEPTH), .IDLE_BYTE(8'hFF), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_cmd(rx_cmd),
    .frame_end(frame_end), .cs_active(cs_active), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_count(tx_count), .int_req(int_req)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] model_fifo[$];
  logic [8:0] exp_rx[$];
  logic [7:0] cur_tx;
  bit         first_in_frame;
  int         exp_fe = 0, got_fe = 0, rx_seen = 0;
  logic [7:0] last_rx_data;
  logic       last_rx_cmd;
  logic       rv_prev = 1'b0, fe_prev = 1'b0;
  logic [7:0] m0, m1, m2, m3, m4;
  int         seen_before;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_pop();
    if (model_fifo.size() > 0) return model_fifo.pop_front();
    return 8'hFF;
  endfunction

  task automatic push(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    if (model_fifo.size() < DEPTH) model_fifo.push_back(d);
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n       = 1'b0;
    cur_tx         = model_pop();
    first_in_frame = 1'b1;
    clks(HP);
  endtask

  task automatic cs_high(input bit was_active);
    clks(HP);
    spi_cs_n = 1'b1;
    if (was_active) exp_fe++;
    clks(2 * HP);
  endtask

  // Master-side byte: MOSI set while SCK low, MISO sampled on the rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      clks(HP);
      spi_sck   = 1'b1;
      mi[7-i]   = spi_miso;
      if (i == 7) exp_rx.push_back({first_in_frame, mo});
      clks(HP);
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      chk("miso_byte", mi, cur_tx);
      cur_tx         = model_pop();
      first_in_frame = 1'b0;
    end
  endtask

  task automatic raw_sck(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = i[0];
      clks(HP);
      spi_sck = 1'b1;
      clks(HP);
      spi_sck = 1'b0;
      chk("wait_cs_active", cs_active, 1'b0);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso", spi_miso, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_cmd", rx_cmd, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    chk("rst_cs_active", cs_active, 1'b0);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_tx_count", tx_count, 3'd0);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      rv_prev = 1'b0;
      fe_prev = 1'b0;
    end else begin
      chk("full_flag", tx_full, (tx_count == 3'(DEPTH)));
      if (rx_valid) begin
        rx_seen++;
        last_rx_data = rx_data;
        last_rx_cmd  = rx_cmd;
        chk("rx_pulse_width", rv_prev, 1'b0);
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected got=%0h exp=none", rx_data);
        end else begin
          e = exp_rx.pop_front();
          chk("rx_data", rx_data, e[7:0]);
          chk("rx_cmd", rx_cmd, e[8]);
        end
      end
      if (frame_end) begin
        got_fe++;
        chk("fe_pulse_width", fe_prev, 1'b0);
      end
      rv_prev = rx_valid;
      fe_prev = frame_end;
    end
  end

  initial begin
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b0; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0; int_req = 1'b0;
    clks(3);
    chk_reset_vals();
    reset = 1'b0;

    // Start-up with chip select already low: nothing is received.
    raw_sck(20);
    chk("wait_miso", spi_miso, 1'b1);
    spi_cs_n = 1'b1;
    clks(2 * HP);
    chk("idle_cs_active", cs_active, 1'b0);

    // Basic three-byte frame
    push(8'h51);
    push(8'hA5);
    chk("count_two", tx_count, 3'd2);
    cs_low();
    xfer(8'h06, 8, m0);
    xfer(8'h57, 8, m1);
    chk("cs_active_in_frame", cs_active, 1'b1);
    xfer(8'h00, 8, m2);
    cs_high(1'b1);
    chk("lit_miso0", m0, 8'h51);
    chk("lit_miso1", m1, 8'hA5);
    chk("lit_miso2", m2, 8'hFF);
    chk("lit_rx_last", last_rx_data, 8'h00);
    chk("lit_rx_last_cmd", last_rx_cmd, 1'b0);
    chk("lit_rx_count", rx_seen, 3);
    chk("count_drained", tx_count, 3'd0);

    // Overfill, then push and pop in the same clk while full
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("full_after4", tx_full, 1'b1);
    push(8'h55);
    chk("count_after5", tx_count, 3'd4);
    chk("full_after5", tx_full, 1'b1);
    spi_cs_n       = 1'b0;
    cur_tx         = model_pop();
    first_in_frame = 1'b1;
    clks(SS);
    tx_data = 8'h66;
    tx_wr   = 1'b1;
    model_fifo.push_back(8'h66);
    @(negedge clk);
    tx_wr = 1'b0;
    chk("count_pushpop", tx_count, 3'd4);
    clks(HP);
    xfer(8'hA0, 8, m0);
    xfer(8'hA1, 8, m1);
    xfer(8'hA2, 8, m2);
    xfer(8'hA3, 8, m3);
    xfer(8'hA4, 8, m4);
    cs_high(1'b1);
    chk("lit_order0", m0, 8'h11);
    chk("lit_order3", m3, 8'h44);
    chk("lit_order4", m4, 8'h66);

    // Partial byte is discarded, popped byte lost
    push(8'hAB);
    seen_before = rx_seen;
    cs_low();
    xfer(8'hC3, 5, m0);
    cs_high(1'b1);
    chk("partial_no_rx", rx_seen, seen_before);
    cs_low();
    xfer(8'h3C, 8, m1);
    cs_high(1'b1);
    chk("lit_after_partial_miso", m1, 8'hFF);
    chk("lit_after_partial_rx", last_rx_data, 8'h3C);
    chk("lit_after_partial_cmd", last_rx_cmd, 1'b1);

    // Interrupt line on MISO
    int_req = 1'b1;
    @(negedge clk);
    chk("int_assert_lat", spi_miso, 1'b0);
    clks(3);
    chk("int_assert", spi_miso, 1'b0);
    int_req = 1'b0;
    @(negedge clk);
    chk("int_release", spi_miso, 1'b1);
    cs_low();
    int_req = 1'b1;
    clks(4);
    chk("int_masked", spi_miso, 1'b1);
    int_req = 1'b0;
    cs_high(1'b1);

    // Reset in the middle of a byte
    push(8'h77);
    push(8'h88);
    cs_low();
    xfer(8'h5A, 3, m0);
    reset = 1'b1;
    clks(2);
    chk_reset_vals();
    model_fifo.delete();
    reset = 1'b0;
    raw_sck(16);
    spi_cs_n = 1'b1;
    clks(2 * HP);
    cs_low();
    xfer(8'h42, 8, m1);
    cs_high(1'b1);
    chk("lit_rearm_miso", m1, 8'hFF);
    chk("lit_rearm_rx", last_rx_data, 8'h42);
    chk("lit_rearm_cmd", last_rx_cmd, 1'b1);

    clks(20);
    chk("rx_all_seen", exp_rx.size(), 0);
    chk("frame_end_count", got_fe, exp_fe);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ch376s_spi_responder.md
Name: ch376s_spi_responder

Overview:
- SPI mode-0 target (responder) that models the CH376S end of the USB host SPI link.
- Used as the bench/loopback counterpart of our SPI master path, and as an on-chip CH376 emulation front end.
- Deserialises MOSI bytes, flags the first byte after chip-select as the command byte, and serialises MISO bytes from a small TX FIFO.
- With chip-select high, drives the CH376 SD0 interrupt line on MISO.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- IDLE_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at a byte boundary.
- SYNC_STAGES, 2, synchroniser flops on spi_sck, spi_cs_n and spi_mosi (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× the SCK frequency
- reset  in  1  synchronous, active-high
- spi_sck  in  1  SPI clock from master, idle low
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data / interrupt line
- rx_data  out  8  last received byte
- rx_valid  out  1  one-clk pulse, rx_data valid
- rx_cmd  out  1  qualifies rx_valid: byte is first of frame
- frame_end  out  1  one-clk pulse on chip-select deassert
- cs_active  out  1  synchronised chip select, active high
- tx_data  in  8  byte to queue for MISO
- tx_wr  in  1  push tx_data
- tx_full  out  1  FIFO full
- tx_count  out  $clog2(TX_DEPTH)+1  FIFO occupancy
- int_req  in  1  pending interrupt, active high

Behaviour:
- Reset values: spi_miso=1, rx_data=0, rx_valid=0, rx_cmd=0, frame_end=0, cs_active=0, tx_full=0, tx_count=0. Reset also clears the FIFO, bit counter and shift registers, and sets state to WAIT_IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised versions. Physical-to-detect latency is SYNC_STAGES+1 clk.
- States:
  - WAIT_IDLE: ignore everything until synced cs_n=1, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: on synced cs_n falling edge, go to ACTIVE. Clear bit_cnt and set first_byte=1. Load tx_shift with the FIFO head (pop) or IDLE_BYTE if the FIFO is empty. Drive spi_miso=tx_shift[7] in that same cycle.
  - ACTIVE, SCK rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++.
    - When bit_cnt reaches 8: next clk rx_data <= byte, rx_valid=1 for exactly one clk, rx_cmd=first_byte. Then clear first_byte and bit_cnt.
  - ACTIVE, SCK falling edge:
    - Mid-byte (bit_cnt 1..7): tx_shift shifts left and spi_miso takes the new MSB.
    - At byte boundary (bit_cnt==0 after a completed byte): load the next FIFO head (pop) or IDLE_BYTE and drive its bit 7.
  - ACTIVE, cs_n rising edge: go to IDLE. frame_end pulses one clk.
    - A partial byte (bit_cnt≠0) is discarded: no rx_valid.
    - A byte popped for a partial transfer is lost, not re-queued.
- cs_active = ~synced cs_n while in IDLE/ACTIVE; it is 0 in WAIT_IDLE.
- MISO with chip-select inactive (IDLE/WAIT_IDLE): spi_miso = ~int_req, registered, so a low level signals interrupt.
- TX FIFO:
  - tx_wr while full: write ignored, count unchanged.
  - Push and pop in the same clk: count unchanged, data order preserved.
  - Pointers wrap modulo TX_DEPTH.
  - tx_full = (tx_count==TX_DEPTH).
- Simultaneous SCK edge and cs_n rising edge in the same clk: the cs_n edge wins and the SCK edge is ignored.
- SCK toggling while in IDLE is ignored.

Test Plan:
- Reset, hold cs_n=0 with SCK running, then raise cs_n → no rx_valid while in WAIT_IDLE; cs_active=0 until cs_n=1, then IDLE.
- Queue 8'h51, 8'hA5. Frame with MOSI bytes 8'h06, 8'h57, 8'h00 → rx_valid ×3 with rx_data 06/57/00, rx_cmd=1 only on 06. MISO returns 51, A5, FF.
- Push 5 bytes with TX_DEPTH=4 → tx_full=1 after the 4th push, 5th ignored, tx_count=4. Push and pop in the same clk at count=4 → count stays 4, order correct.
- Drop cs_n after 5 SCK rising edges of a byte → no rx_valid, frame_end one-clk pulse. Next frame's first byte has rx_cmd=1 and the bit counter restarts.
- cs_n high, int_req 0→1→0 → spi_miso 1→0→1 with registered latency. With cs_n low, int_req has no effect on MISO.
- Assert reset mid-byte inside a frame → all outputs at reset values, FIFO empty. Responder re-arms only after cs_n goes high.
